mst_driver: RTL and testbench
=============================

Name: mst_driver

Overview:
- Randomised AXI4 master traffic generator and response checker for the crossbar SVUT benches.
- Connects to a crossbar slave interface (master side); its transactions reach slv_monitor instances on the far side.
- Issues single-beat writes and reads at LFSR-driven addresses and times, tracks outstanding requests, and checks each B/R response against the package expectation function.

Parameters:
AXI_ADDR_W, 8, address width in bits
AXI_ID_W, 8, ID width in bits
AXI_DATA_W, 8, data width in bits (multiple of 8)
MST_ID, 'h10, fixed AWID/ARID driven by this master
OSTDREQ_NUM, 4, maximum outstanding writes and maximum outstanding reads (power of 2)
TIMEOUT, 1000, cycles without a response before error
KEY, 'hFFFFFFFF, LFSR seed

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
en  in  1  traffic enable; 0 = no new requests, outstanding ones still complete
error  out  1  sticky checker error
wr_done  out  16  completed write count
rd_done  out  16  completed read count
aw*/w*  out/in  AXI4  full AW and W channel (awvalid, awready, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid, wvalid, wready, wlast, wdata, wstrb)
b*  in/out  AXI4  bvalid, bready, bid, bresp
ar*  out/in  AXI4  full AR channel
r*  in/out  AXI4  rvalid, rready, rid, rresp, rdata, rlast

Behaviour:
- Reset values: all valids 0, bready/rready 0, error 0, wr_done/rd_done 0, LFSRs = KEY, outstanding FIFOs empty.
- Constant fields: awlen/arlen 0, wlast 1, wstrb all ones, size = log2(AXI_DATA_W/8), burst 2'b01, lock/cache/prot/qos/region 0, ID = MST_ID.
- Write issue:
  - Start condition: en, write FIFO not full, no write in flight on AW/W, and aw_lfsr[0]=1.
  - On start, assert awvalid and wvalid together. awaddr = aw_lfsr[AXI_ADDR_W-1:0]; wdata = aw_lfsr[AXI_DATA_W-1:0] (replicated if wider than 32).
  - Both held stable until their own handshake. Each drops independently after its handshake.
  - Next write starts no earlier than the cycle after both handshakes are done.
  - aw_lfsr advances once per completed write issue.
  - Push {awid, gen_resp(awaddr)[1:0]} into the write FIFO on the AW handshake.
- Read issue: same scheme with ar_lfsr. On the AR handshake, push {arid, gen_resp(araddr)[1:0], gen_resp(araddr)[AXI_DATA_W-1:0]}.
- bready and rready are driven from bits 0 of separate LFSRs. Those LFSRs shift every cycle.
- B check on handshake:
  - FIFO empty → error.
  - bid≠head id or bresp≠head resp → error.
  - Otherwise pop and increment wr_done.
- R check on handshake:
  - FIFO empty → error.
  - rid, rresp or rdata mismatch → error.
  - rlast=0 → error.
  - Otherwise pop and increment rd_done.
- Responses are in order per ID; a single fixed ID means FIFO-head comparison is exact.
- Timeout: per-direction counter runs while its FIFO is non-empty and resets on each B/R handshake. Reaching TIMEOUT sets error.
- error: set the cycle after detection, cleared only by areset. wr_done/rd_done wrap at 16 bits.
- FIFO full: no new AW/AR is started. A request already started completes its handshake; start is gated on space, so a push can never overflow.
- Simultaneous push/pop on the same FIFO is legal in full and empty states.
- en dropped mid-request: the current valid stays asserted until its handshake (AXI rule).
- areset mid-operation: immediate return to reset values; outstanding state is discarded.

Decomposition:
- Package axicb_checker_pkg holds:
  - gen_resp(addr): returns 32'(addr) ^ 32'hDEADBEEF. Response = bits[1:0]; data = low bits. slv_monitor uses the same function.
  - AXI constants BURST_INCR=2'b01, OKAY=2'b00, SLVERR=2'b10.
- Sub-modules: reuse axicb_scfifo (ADDR_WIDTH=log2(OSTDREQ_NUM), PASS_THRU=0) for each outstanding FIFO, and lfsr32 for each random source. No new sub-module.

Test Plan:
- Write, AXI_ADDR_W=8: awaddr 8'h10, slave returns bid 'h10, bresp 2'b11 → no error, wr_done=1.
- Same write, slave returns bresp 2'b00 → error=1 the next cycle and stays 1 after further traffic.
- Read, AXI_DATA_W=8: araddr 8'h10, slave returns rdata 8'hFF, rresp 2'b11, rlast=1 → no error, rd_done=1. Repeat with rlast=0 → error=1.
- Slave holds bready-side idle (bvalid=0) while 4 writes are accepted → awvalid stays 0 for the 5th. One B pop → the 5th write issues within the LFSR gate window.
- No B for 1000 cycles with 1 write outstanding → error=1 at cycle 1000. Unsolicited bvalid with the FIFO empty → error=1.
- areset asserted mid-transfer with awvalid=1 and 2 outstanding → awvalid=0 and counts=0 immediately. After release, traffic restarts from the KEY sequence with no error.

Source files
------------

// File: rtl/mst_driver_pkg.sv
// Shared checker definitions: AXI constants and the address-to-response
// function that both this master and slv_monitor use.
package axicb_checker_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;

  // The slave derives its response from the address it saw. Bits [1:0] are
  // the response code and the low bits are the read data.
  function automatic logic [31:0] gen_resp(input logic [31:0] addr);
    return addr ^ 32'hDEADBEEF;
  endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// With PASS_THRU set, a push into an empty FIFO is visible on data_out in the
// same cycle.
module axicb_scfifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int PASS_THRU  = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  pull,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  mem_empty;
  logic                  do_push;
  logic                  do_pull;

  assign mem_empty = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty     = (PASS_THRU != 0) ? (mem_empty && !push) : mem_empty;
  assign data_out  = (PASS_THRU != 0 && mem_empty) ? data_in
                                                   : mem[rd_ptr[ADDR_WIDTH-1:0]];
  // A pop in the same cycle frees the slot, so push while full is allowed then.
  assign do_push   = push && (!full || pull);
  assign do_pull   = pull && !empty;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  // Pointer bookkeeping for push and pop.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pull) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR (x^32 + x^22 + x^2 + x + 1) loaded with KEY on reset.
module lfsr32 #(
  parameter logic [31:0] KEY = 32'hFFFFFFFF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  output logic [31:0] lfsr
);

  // Shift one position whenever the owner asks for a new value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  lfsr <= KEY;
    else if (en) lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

endmodule

// File: rtl/mst_driver.sv
// Randomised single-beat AXI4 master: issues LFSR-timed writes and reads,
// remembers what the slave must answer, and flags any wrong, unexpected or
// missing response on a sticky error output.
module mst_driver
  import axicb_checker_pkg::*;
#(
  parameter int                  AXI_ADDR_W  = 8,
  parameter int                  AXI_ID_W    = 8,
  parameter int                  AXI_DATA_W  = 8,
  parameter logic [AXI_ID_W-1:0] MST_ID      = 'h10,
  parameter int                  OSTDREQ_NUM = 4,
  parameter int                  TIMEOUT     = 1000,
  parameter logic [31:0]         KEY         = 32'hFFFFFFFF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    en,
  output logic                    error,
  output logic [15:0]             wr_done,
  output logic [15:0]             rd_done,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic [3:0]              awqos,
  output logic [3:0]              awregion,
  output logic [AXI_ID_W-1:0]     awid,
  output logic                    wvalid,
  input  logic                    wready,
  output logic                    wlast,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [AXI_ID_W-1:0]     bid,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  output logic [AXI_ID_W-1:0]     arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [1:0]              rresp,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic                    rlast
);

  localparam int FIFO_AW = $clog2(OSTDREQ_NUM);
  localparam int WR_W    = AXI_ID_W + 2;
  localparam int RD_W    = AXI_ID_W + 2 + AXI_DATA_W;
  localparam int REP     = (AXI_DATA_W + 31) / 32;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  logic [31:0]         aw_lfsr, ar_lfsr, b_lfsr, r_lfsr;
  logic [REP*32-1:0]   aw_rep;
  logic [31:0]         wr_resp, rd_resp;
  logic [WR_W-1:0]     wr_head;
  logic [RD_W-1:0]     rd_head;
  logic                wr_full, wr_empty, rd_full, rd_empty;
  logic                wr_idle, wr_start, wr_end, wr_step, wr_push, wr_pop;
  logic                ar_start, ar_step, rd_push, rd_pop;
  logic                b_hs, b_ok, b_err, r_hs, r_ok, r_err;
  logic [TMO_W-1:0]    wr_tmo, rd_tmo;
  logic                lfsr_unused;

  assign awlen    = '0;
  assign awsize   = 3'($clog2(AXI_DATA_W / 8));
  assign awburst  = BURST_INCR;
  assign awlock   = 1'b0;
  assign awcache  = '0;
  assign awprot   = '0;
  assign awqos    = '0;
  assign awregion = '0;
  assign awid     = MST_ID;
  assign arlen    = '0;
  assign arsize   = 3'($clog2(AXI_DATA_W / 8));
  assign arburst  = BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = '0;
  assign arprot   = '0;
  assign arqos    = '0;
  assign arregion = '0;
  assign arid     = MST_ID;
  assign wlast    = 1'b1;
  assign wstrb    = '1;

  // Address and data come straight from the LFSR, which is frozen while a
  // request is in flight, so they stay stable until the handshake.
  assign aw_rep = {REP{aw_lfsr}};
  assign awaddr = aw_lfsr[AXI_ADDR_W-1:0];
  assign wdata  = aw_rep[AXI_DATA_W-1:0];
  assign araddr = ar_lfsr[AXI_ADDR_W-1:0];

  // Bit 0 gates the start; while idle and gated off the LFSR keeps stepping
  // so that the gate eventually opens.
  assign wr_idle  = !awvalid && !wvalid;
  assign wr_start = en && !wr_full && wr_idle && aw_lfsr[0];
  assign wr_end   = !wr_idle && (!awvalid || awready) && (!wvalid || wready);
  assign wr_step  = wr_end || (en && !wr_full && wr_idle && !aw_lfsr[0]);
  assign wr_push  = awvalid && awready;
  assign ar_start = en && !rd_full && !arvalid && ar_lfsr[0];
  assign ar_step  = (arvalid && arready) || (en && !rd_full && !arvalid && !ar_lfsr[0]);
  assign rd_push  = arvalid && arready;

  assign wr_resp = gen_resp(32'(awaddr));
  assign rd_resp = gen_resp(32'(araddr));

  assign b_hs   = bvalid && bready;
  assign b_ok   = !wr_empty && (bid == wr_head[WR_W-1 -: AXI_ID_W]) && (bresp == wr_head[1:0]);
  assign b_err  = b_hs && !b_ok;
  assign wr_pop = b_hs && b_ok;
  assign r_hs   = rvalid && rready;
  assign r_ok   = !rd_empty && (rid == rd_head[RD_W-1 -: AXI_ID_W]) &&
                  (rresp == rd_head[AXI_DATA_W+1:AXI_DATA_W]) &&
                  (rdata == rd_head[AXI_DATA_W-1:0]) && rlast;
  assign r_err  = r_hs && !r_ok;
  assign rd_pop = r_hs && r_ok;

  assign lfsr_unused = ^{aw_lfsr, ar_lfsr, b_lfsr, r_lfsr, aw_rep, wr_resp, rd_resp, OKAY, SLVERR};

  lfsr32 #(.KEY(KEY)) u_aw_lfsr (.aclk(aclk), .areset(areset), .en(wr_step), .lfsr(aw_lfsr));
  lfsr32 #(.KEY(KEY)) u_ar_lfsr (.aclk(aclk), .areset(areset), .en(ar_step), .lfsr(ar_lfsr));
  lfsr32 #(.KEY(KEY)) u_b_lfsr  (.aclk(aclk), .areset(areset), .en(1'b1),    .lfsr(b_lfsr));
  lfsr32 #(.KEY(KEY)) u_r_lfsr  (.aclk(aclk), .areset(areset), .en(1'b1),    .lfsr(r_lfsr));

  axicb_scfifo #(.DATA_WIDTH(WR_W), .ADDR_WIDTH(FIFO_AW), .PASS_THRU(0)) u_wr_fifo (
    .aclk(aclk), .areset(areset),
    .push(wr_push), .data_in({awid, wr_resp[1:0]}), .full(wr_full),
    .pull(wr_pop), .data_out(wr_head), .empty(wr_empty)
  );

  axicb_scfifo #(.DATA_WIDTH(RD_W), .ADDR_WIDTH(FIFO_AW), .PASS_THRU(0)) u_rd_fifo (
    .aclk(aclk), .areset(areset),
    .push(rd_push), .data_in({arid, rd_resp[1:0], AXI_DATA_W'(rd_resp)}), .full(rd_full),
    .pull(rd_pop), .data_out(rd_head), .empty(rd_empty)
  );

  // Request valids: raised together on start, each dropped by its own handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
    end else begin
      if (wr_start) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else begin
        if (awready) awvalid <= 1'b0;
        if (wready)  wvalid  <= 1'b0;
      end
      if (ar_start)     arvalid <= 1'b1;
      else if (arready) arvalid <= 1'b0;
    end
  end

  // Response-side readiness, completion counters and timeout counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bready  <= 1'b0;
      rready  <= 1'b0;
      wr_done <= '0;
      rd_done <= '0;
      wr_tmo  <= '0;
      rd_tmo  <= '0;
    end else begin
      bready <= b_lfsr[0];
      rready <= r_lfsr[0];
      if (wr_pop) wr_done <= wr_done + 16'd1;
      if (rd_pop) rd_done <= rd_done + 16'd1;
      if (b_hs || wr_empty)                  wr_tmo <= '0;
      else if (wr_tmo != TMO_W'(TIMEOUT))    wr_tmo <= wr_tmo + 1'b1;
      if (r_hs || rd_empty)                  rd_tmo <= '0;
      else if (rd_tmo != TMO_W'(TIMEOUT))    rd_tmo <= rd_tmo + 1'b1;
    end
  end

  // Sticky error: any bad or unexpected response, or a response that never came.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) error <= 1'b0;
    else if (b_err || r_err || (wr_tmo == TMO_W'(TIMEOUT)) || (rd_tmo == TMO_W'(TIMEOUT)))
      error <= 1'b1;
  end

endmodule

// File: tb/tb_mst_driver.sv
// Directed bench for mst_driver: the bench plays the slave, derives each
// expected response from the observed address, and checks counts and error.
module tb_mst_driver;

  localparam logic [7:0] MID = 8'h10;

  logic       aclk = 1'b0;
  logic       areset, en, error;
  logic [15:0] wr_done, rd_done;
  logic       awvalid, awready, awlock, wvalid, wready, wlast;
  logic [7:0] awaddr, awlen, awid, wdata;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [3:0] awcache, awqos, awregion;
  logic [0:0] wstrb;
  logic       bvalid, bready;
  logic [7:0] bid;
  logic [1:0] bresp;
  logic       arvalid, arready, arlock;
  logic [7:0] araddr, arlen, arid;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [3:0] arcache, arqos, arregion;
  logic       rvalid, rready, rlast;
  logic [7:0] rid, rdata;
  logic [1:0] rresp;

  int checks   = 0;
  int failures = 0;

  mst_driver dut (
    .aclk(aclk), .areset(areset), .en(en), .error(error),
    .wr_done(wr_done), .rd_done(rd_done),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awqos(awqos), .awregion(awregion), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arqos(arqos), .arregion(arregion), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp),
    .rdata(rdata), .rlast(rlast)
  );

  // Free-running 100 MHz clock.
  always #5 aclk = ~aclk;

  // Independent reference for what the slave must answer for an address.
  function automatic logic [31:0] model_resp(input logic [7:0] addr);
    return {24'h000000, addr} ^ 32'hDEADBEEF;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; en = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rid = '0; rresp = '0; rdata = '0; rlast = 1'b0;
    repeat (3) step();
    areset = 1'b0;
  endtask

  task automatic accept_write(output logic [7:0] addr, output logic [7:0] data, output bit ok);
    int n = 0;
    addr = '0; data = '0; ok = 1'b0;
    while (!awvalid && n < 300) begin step(); n++; end
    if (awvalid && wvalid) begin
      addr = awaddr; data = wdata;
      awready = 1'b1; wready = 1'b1;
      step();
      awready = 1'b0; wready = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic accept_read(output logic [7:0] addr, output bit ok);
    int n = 0;
    addr = '0; ok = 1'b0;
    while (!arvalid && n < 300) begin step(); n++; end
    if (arvalid) begin
      addr = araddr;
      arready = 1'b1;
      step();
      arready = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] resp, output bit ok);
    int n = 0;
    bvalid = 1'b1; bid = id; bresp = resp;
    while (!bready && n < 300) begin step(); n++; end
    ok = bready;
    step();
    bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [7:0] id, input logic [1:0] resp, input logic [7:0] data,
                        input logic last, output bit ok);
    int n = 0;
    rvalid = 1'b1; rid = id; rresp = resp; rdata = data; rlast = last;
    while (!rready && n < 300) begin step(); n++; end
    ok = rready;
    step();
    rvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; en = 1'b1;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; rid = '0; rresp = '0; rdata = '0; rlast = 1'b0;
    repeat (3) step();
    checks++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin failures++;
      $display("[TB] FAIL reset_valids: got %b expected 000", {awvalid, wvalid, arvalid}); end
    checks++; if ({bready, rready, error} !== 3'b000) begin failures++;
      $display("[TB] FAIL reset_ready_error: got %b expected 000", {bready, rready, error}); end
    checks++; if ({wr_done, rd_done} !== 32'h0) begin failures++;
      $display("[TB] FAIL reset_counts: got %h expected 00000000", {wr_done, rd_done}); end
    checks++; if ({awlen, awsize, awburst, awid, wlast, wstrb} !== {8'h00, 3'd0, 2'b01, MID, 1'b1, 1'b1}) begin failures++;
      $display("[TB] FAIL aw_w_constants: got %h expected %h", {awlen, awsize, awburst, awid, wlast, wstrb},
               {8'h00, 3'd0, 2'b01, MID, 1'b1, 1'b1}); end
    checks++; if ({arlen, arsize, arburst, arid, arlock, awlock} !== {8'h00, 3'd0, 2'b01, MID, 2'b00}) begin failures++;
      $display("[TB] FAIL ar_constants: got %h expected %h", {arlen, arsize, arburst, arid, arlock, awlock},
               {8'h00, 3'd0, 2'b01, MID, 2'b00}); end
    areset = 1'b0;
  endtask

  task automatic test_write_ok();
    logic [7:0] a, d;
    logic [31:0] r;
    bit ok, okb;
    en = 1'b1;
    accept_write(a, d, ok);
    r = model_resp(a);
    send_b(MID, r[1:0], okb);
    checks++; if ({ok, okb} !== 2'b11) begin failures++;
      $display("[TB] FAIL write_handshake: got %b expected 11", {ok, okb}); end
    checks++; if (a !== 8'hFF) begin failures++;
      $display("[TB] FAIL first_awaddr: got %h expected ff", a); end
    checks++; if (d !== a) begin failures++;
      $display("[TB] FAIL first_wdata: got %h expected %h", d, a); end
    step();
    checks++; if ({error, wr_done} !== {1'b0, 16'd1}) begin failures++;
      $display("[TB] FAIL write_ok: got error=%0d wr_done=%0d expected error=0 wr_done=1", error, wr_done); end
  endtask

  task automatic test_read_ok();
    logic [7:0] a;
    logic [31:0] r;
    bit ok, okr;
    accept_read(a, ok);
    r = model_resp(a);
    send_r(MID, r[1:0], r[7:0], 1'b1, okr);
    checks++; if ({ok, okr, a} !== {2'b11, 8'hFF}) begin failures++;
      $display("[TB] FAIL read_handshake: got ok=%b araddr=%h expected ok=11 araddr=ff", {ok, okr}, a); end
    step();
    checks++; if ({error, rd_done} !== {1'b0, 16'd1}) begin failures++;
      $display("[TB] FAIL read_ok: got error=%0d rd_done=%0d expected error=0 rd_done=1", error, rd_done); end
  endtask

  task automatic test_outstanding_full();
    logic [7:0] a [5];
    logic [7:0] d;
    logic [31:0] r;
    bit ok, all_ok, seen;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept_write(a[i], d, ok);
      all_ok &= ok;
    end
    seen = 1'b0;
    repeat (100) begin step(); if (awvalid) seen = 1'b1; end
    checks++; if ({all_ok, seen} !== 2'b10) begin failures++;
      $display("[TB] FAIL fifo_full_blocks: got accepted=%0d awvalid_seen=%0d expected 1 0", all_ok, seen); end
    r = model_resp(a[0]);
    send_b(MID, r[1:0], ok);
    accept_write(a[4], d, ok);
    checks++; if ({ok, d} !== {1'b1, a[4]}) begin failures++;
      $display("[TB] FAIL fifth_write: got ok=%0d wdata=%h expected ok=1 wdata=%h", ok, d, a[4]); end
    for (int i = 1; i < 5; i++) begin
      r = model_resp(a[i]);
      send_b(MID, r[1:0], ok);
    end
    step();
    checks++; if ({error, wr_done} !== {1'b0, 16'd6}) begin failures++;
      $display("[TB] FAIL fifo_drain: got error=%0d wr_done=%0d expected error=0 wr_done=6", error, wr_done); end
  endtask

  task automatic test_bresp_error();
    logic [7:0] a, d;
    logic [31:0] r;
    bit ok;
    accept_write(a, d, ok);
    r = model_resp(a);
    send_b(MID, ~r[1:0], ok);
    checks++; if ({error, wr_done} !== {1'b1, 16'd6}) begin failures++;
      $display("[TB] FAIL bad_bresp: got error=%0d wr_done=%0d expected error=1 wr_done=6", error, wr_done); end
    send_b(MID, r[1:0], ok);
    step();
    checks++; if ({error, wr_done} !== {1'b1, 16'd7}) begin failures++;
      $display("[TB] FAIL error_sticky: got error=%0d wr_done=%0d expected error=1 wr_done=7", error, wr_done); end
  endtask

  task automatic test_rlast_error();
    logic [7:0] a;
    logic [31:0] r;
    bit ok;
    do_reset();
    en = 1'b1;
    accept_read(a, ok);
    r = model_resp(a);
    send_r(MID, r[1:0], r[7:0], 1'b0, ok);
    checks++; if ({error, rd_done} !== {1'b1, 16'd0}) begin failures++;
      $display("[TB] FAIL rlast_low: got error=%0d rd_done=%0d expected error=1 rd_done=0", error, rd_done); end
  endtask

  task automatic test_timeout();
    logic [7:0] a, d;
    bit ok, early;
    do_reset();
    en = 1'b1;
    accept_write(a, d, ok);
    en = 1'b0;
    early = 1'b0;
    repeat (980) begin step(); if (error) early = 1'b1; end
    repeat (40) step();
    checks++; if ({ok, early, error} !== 3'b101) begin failures++;
      $display("[TB] FAIL timeout: got ok=%0d early=%0d error=%0d expected 1 0 1", ok, early, error); end
  endtask

  task automatic test_unsolicited_b();
    bit ok;
    do_reset();
    repeat (2) step();
    checks++; if (error !== 1'b0) begin failures++;
      $display("[TB] FAIL idle_no_error: got %0d expected 0", error); end
    send_b(MID, 2'b00, ok);
    checks++; if ({ok, error} !== 2'b11) begin failures++;
      $display("[TB] FAIL unsolicited_b: got ok=%0d error=%0d expected 1 1", ok, error); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] a [3];
    logic [7:0] b, d;
    logic [31:0] r;
    bit ok;
    int n;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) accept_write(a[i], d, ok);
    r = model_resp(a[0]);
    send_b(MID, r[1:0], ok);
    n = 0;
    while (!awvalid && n < 300) begin step(); n++; end
    checks++; if ({awvalid, wr_done} !== {1'b1, 16'd1}) begin failures++;
      $display("[TB] FAIL pre_reset_state: got awvalid=%0d wr_done=%0d expected 1 1", awvalid, wr_done); end
    areset = 1'b1;
    #1;
    checks++; if ({awvalid, wvalid, wr_done, rd_done, error} !== {2'b00, 32'h0, 1'b0}) begin failures++;
      $display("[TB] FAIL async_reset: got awvalid=%0d wvalid=%0d wr_done=%0d rd_done=%0d error=%0d expected all 0",
               awvalid, wvalid, wr_done, rd_done, error); end
    repeat (2) step();
    areset = 1'b0;
    accept_write(b, d, ok);
    checks++; if ({ok, b} !== {1'b1, 8'hFF}) begin failures++;
      $display("[TB] FAIL restart_addr: got ok=%0d awaddr=%h expected ok=1 awaddr=ff", ok, b); end
    r = model_resp(b);
    send_b(MID, r[1:0], ok);
    step();
    checks++; if ({error, wr_done} !== {1'b0, 16'd1}) begin failures++;
      $display("[TB] FAIL restart_clean: got error=%0d wr_done=%0d expected error=0 wr_done=1", error, wr_done); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_write_ok();
    test_read_ok();
    test_outstanding_full();
    test_bresp_error();
    test_rlast_error();
    test_timeout();
    test_unsolicited_b();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
